// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block and its duty divider.
// DUTY_STEPS is the generator's duty scale and must stay in step with it.
package pwm_capture_pkg;

    localparam int DUTY_STEPS = 10;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } meas_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/pwm_capture_div.sv
// Sequential restoring divider: duty = round_half_up(DUTY_STEPS*hi/per).
// One subtraction per cycle; done is asserted in the cycle the remainder no longer fits.
//
// state | meaning
// IDLE  | no division in flight
// RUN   | subtracting per from rem once per cycle
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] hi,
    input  logic [CNT_W-1:0] per,
    output logic             busy,
    output logic             done,
    output logic [3:0]       quot
);

    localparam int REM_W = CNT_W + 5;
    localparam logic [REM_W-1:0] STEPS = REM_W'(DUTY_STEPS);

    div_state_t       state, state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_init;
    logic [REM_W-1:0] div_ext;
    logic [CNT_W-1:0] div;
    logic             fits;

    assign rem_init = REM_W'(hi) * STEPS + REM_W'(per >> 1);
    assign div_ext  = REM_W'(div);
    assign fits     = (rem >= div_ext);
    assign busy     = (state == RUN);
    assign done     = busy && !fits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start beats done so a new period can launch in the cycle the old one finishes
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = RUN;
        end else if (done) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            div  <= '0;
            quot <= '0;
        end else if (start && !abort) begin
            rem  <= rem_init;
            div  <= per;
            quot <= '0;
        end else if (busy && fits) begin
            rem  <= rem - div_ext;
            quot <= quot + 4'd1;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM line and reports duty in tenths.
// Also flags a stuck line after TIMEOUT cycles without a synchronized edge.
//
// state     | meaning
// WAIT_RISE | no period in progress, waiting for a rising edge
// HIGH      | counting the high phase of the current period
// LOW       | counting the low phase; next rise completes the period
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [3:0]       duty_tenths,
    output logic             meas_valid,
    output logic             locked,
    output logic             overrun
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_STUCK = IDLE_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s, pwm_d, rise, fall;
    logic [IDLE_W-1:0]      idle_cnt;
    logic                   timeout_hit;
    meas_state_t            state, state_nxt;
    logic                   cnt_ld, cnt_inc, hi_cap, period_done;
    logic [CNT_W-1:0]       cnt, hi_lat, pend_hi, pend_per;
    logic                   div_start, div_abort, div_busy, div_done;
    logic [3:0]             div_quot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s && !pwm_d;
    assign fall  = !pwm_s && pwm_d;

    // idle_cnt parks at TIMEOUT so a stuck line reports only once
    assign timeout_hit = ena && !(rise || fall) && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!ena || rise || fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_STUCK) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_RISE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_ld      = 1'b0;
        cnt_inc     = 1'b0;
        hi_cap      = 1'b0;
        period_done = 1'b0;
        if (!ena || timeout_hit) begin
            state_nxt = WAIT_RISE;
        end else begin
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_ld    = 1'b1;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    cnt_inc = 1'b1;
                    if (fall) begin
                        hi_cap    = 1'b1;
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_done = 1'b1;
                        cnt_ld      = 1'b1;
                        state_nxt   = HIGH;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_nxt = WAIT_RISE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            hi_lat <= '0;
        end else begin
            if (!ena || timeout_hit) begin
                cnt <= '0;
            end else if (cnt_ld) begin
                cnt <= CNT_W'(1);
            end else if (cnt_inc && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (hi_cap) begin
                hi_lat <= cnt;
            end
        end
    end

    assign div_start = period_done && (!div_busy || div_done);
    assign div_abort = !ena || timeout_hit;

    // operands of the division in flight, kept apart from hi_lat so dropped periods cannot disturb them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_hi  <= '0;
            pend_per <= '0;
        end else if (div_start) begin
            pend_hi  <= hi_lat;
            pend_per <= cnt;
        end
    end

    pwm_duty_div #(.CNT_W(CNT_W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .abort (div_abort),
        .hi    (hi_lat),
        .per   (cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty_tenths <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            overrun     <= 1'b0;
        end else if (!ena) begin
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overrun    <= 1'b0;
        end else if (timeout_hit) begin
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty_tenths <= pwm_s ? 4'(DUTY_STEPS) : 4'd0;
            meas_valid  <= 1'b1;
            locked      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            meas_valid <= div_done;
            overrun    <= period_done && div_busy && !div_done;
            if (div_done) begin
                high_cnt    <= pend_hi;
                period_cnt  <= pend_per;
                duty_tenths <= div_quot;
                locked      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: event-level reference model plus directed and random PWM stimulus.
module tb_pwm_capture;

    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        pwm_in;
    logic [15:0] high_cnt;
    logic [15:0] period_cnt;
    logic [3:0]  duty_tenths;
    logic        meas_valid;
    logic        locked;
    logic        overrun;

    pwm_capture #(.CNT_W(16), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .duty_tenths (duty_tenths),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .overrun     (overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generator ----------------
    int gen_mode = 0;
    int gen_level = 0;
    int gen_h = 5;
    int gen_l = 5;
    int gh, gl;

    initial begin
        pwm_in = 1'b0;
        forever begin
            if (gen_mode == 0) begin
                pwm_in = (gen_level != 0);
                @(posedge clk); #1;
            end else begin
                if (gen_mode == 2) begin
                    gh = $urandom_range(1, 12);
                    gl = $urandom_range(1, 12);
                end else begin
                    gh = gen_h;
                    gl = gen_l;
                end
                repeat (gh) begin pwm_in = 1'b1; @(posedge clk); #1; end
                repeat (gl) begin pwm_in = 1'b0; @(posedge clk); #1; end
            end
        end
    end

    // ---------------- reference model ----------------
    // Works on edge timestamps: a change of pwm_in sampled at clock k is acted upon at clock k+2.
    int cyc = 0;
    int last_edge = 0;
    int t_rise = 0, t_fall = 0, fin_k = 0;
    bit have_start = 0, have_fall = 0, div_active = 0, armed = 1;
    int pend_h = 0, pend_p = 0, pend_q = 0;
    bit p1 = 0, p2 = 0, p3 = 0;
    int m_high = 0, m_per = 0, m_duty = 0;
    bit m_valid = 0, m_locked = 0, m_ovr = 0;

    task automatic model_step();
        bit s, pv, r, f;
        int p, h, q;
        cyc++;
        m_valid = 0;
        m_ovr   = 0;
        if (rst) begin
            p1 = 0; p2 = 0; p3 = 0;
            have_start = 0; have_fall = 0; div_active = 0; armed = 1;
            last_edge = cyc;
            m_high = 0; m_per = 0; m_duty = 0; m_locked = 0;
            return;
        end
        s  = p2;
        pv = p3;
        p3 = p2; p2 = p1; p1 = pwm_in;
        r = s && !pv;
        f = !s && pv;
        if (!ena) begin
            have_start = 0; div_active = 0; m_locked = 0; armed = 1;
            last_edge = cyc;
            return;
        end
        if (r || f) begin
            last_edge = cyc;
            armed = 1;
        end else if (armed && (cyc - last_edge == TIMEOUT)) begin
            m_high = 0; m_per = 0; m_duty = s ? 10 : 0;
            m_valid = 1; m_locked = 0;
            div_active = 0; have_start = 0; armed = 0;
            return;
        end
        if (div_active && cyc == fin_k) begin
            m_high = pend_h; m_per = pend_p; m_duty = pend_q;
            m_valid = 1; m_locked = 1;
            div_active = 0;
        end
        if (f && have_start) begin
            t_fall = cyc;
            have_fall = 1;
        end
        if (r) begin
            if (have_start && have_fall) begin
                p = cyc - t_rise;
                h = t_fall - t_rise;
                q = (10 * h + p / 2) / p;
                if (div_active) begin
                    m_ovr = 1;
                end else begin
                    div_active = 1;
                    fin_k  = cyc + q + 1;
                    pend_h = h; pend_p = p; pend_q = q;
                end
            end
            t_rise = cyc;
            have_start = 1;
            have_fall = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("cyc_high_cnt",   high_cnt,    m_high);
            chk("cyc_period_cnt", period_cnt,  m_per);
            chk("cyc_duty",       duty_tenths, m_duty);
            chk("cyc_meas_valid", meas_valid,  m_valid);
            chk("cyc_locked",     locked,      m_locked);
            chk("cyc_overrun",    overrun,     m_ovr);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_result(input string nm, input int per, input int hi, input int duty, input int maxc);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (meas_valid && period_cnt == 16'(per)) found = 1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no result with period %0d within %0d cycles", nm, per, maxc);
        end else begin
            chk({nm, "_high"},   high_cnt,    hi);
            chk({nm, "_duty"},   duty_tenths, duty);
            chk({nm, "_locked"}, locked,      1);
            chk({nm, "_model"},  m_duty,      duty);
        end
    endtask

    task automatic set_gen(input int mode, input int h, input int l, input int lvl);
        gen_mode = mode; gen_h = h; gen_l = l; gen_level = lvl;
    endtask

    int n_valid, n_ovr, cap_high, cap_per, cap_duty, cap_locked;

    initial begin
        rst = 1'b0;
        ena = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_high",   high_cnt,    0);
        chk("rst_period", period_cnt,  0);
        chk("rst_duty",   duty_tenths, 0);
        chk("rst_valid",  meas_valid,  0);
        chk("rst_locked", locked,      0);
        chk("rst_ovr",    overrun,     0);
        #2 rst = 1'b0;
        @(posedge clk); #1 ena = 1'b1;

        set_gen(1, 5, 5, 0);
        wait_result("p10", 10, 5, 5, 80);
        set_gen(1, 7, 13, 0);
        wait_result("p20", 20, 7, 4, 120);
        set_gen(1, 1, 2, 0);
        wait_result("p3", 3, 1, 3, 80);

        // stuck low
        set_gen(1, 5, 5, 0);
        wait_result("relock_a", 10, 5, 5, 80);
        set_gen(0, 0, 0, 0);
        repeat (40) @(negedge clk);
        n_valid = 0; cap_high = 99; cap_per = 99; cap_duty = 99; cap_locked = 99;
        repeat (1100) begin
            @(negedge clk);
            if (meas_valid) begin
                n_valid++;
                cap_high = high_cnt; cap_per = period_cnt;
                cap_duty = duty_tenths; cap_locked = locked;
            end
        end
        chk("to_low_pulses", n_valid,    1);
        chk("to_low_high",   cap_high,   0);
        chk("to_low_period", cap_per,    0);
        chk("to_low_duty",   cap_duty,   0);
        chk("to_low_locked", cap_locked, 0);

        // stuck high
        set_gen(1, 5, 5, 0);
        wait_result("relock_b", 10, 5, 5, 80);
        set_gen(0, 0, 0, 1);
        repeat (40) @(negedge clk);
        n_valid = 0; cap_duty = 99; cap_per = 99;
        repeat (1100) begin
            @(negedge clk);
            if (meas_valid) begin
                n_valid++;
                cap_duty = duty_tenths; cap_per = period_cnt;
            end
        end
        chk("to_high_pulses", n_valid,  1);
        chk("to_high_duty",   cap_duty, 10);
        chk("to_high_period", cap_per,  0);

        // overrun with period 2
        set_gen(1, 1, 1, 0);
        n_ovr = 0;
        repeat (100) begin
            @(negedge clk);
            if (overrun) n_ovr++;
        end
        chk("ovr_seen", (n_ovr > 0) ? 1 : 0, 1);
        wait_result("p2", 2, 1, 5, 40);

        // async reset in the middle of a division
        set_gen(1, 5, 5, 0);
        wait_result("p10b", 10, 5, 5, 80);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_high",   high_cnt,    0);
        chk("arst_period", period_cnt,  0);
        chk("arst_duty",   duty_tenths, 0);
        chk("arst_valid",  meas_valid,  0);
        chk("arst_locked", locked,      0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        wait_result("post_rst", 10, 5, 5, 80);

        // enable dropped while locked
        @(posedge clk); #1 ena = 1'b0;
        n_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (meas_valid) n_valid++;
        end
        chk("ena_lo_pulses", n_valid,     0);
        chk("ena_lo_locked", locked,      0);
        chk("ena_lo_high",   high_cnt,    5);
        chk("ena_lo_period", period_cnt,  10);
        chk("ena_lo_duty",   duty_tenths, 5);
        @(posedge clk); #1 ena = 1'b1;
        wait_result("ena_hi", 10, 5, 5, 80);

        // random periods with enable blips
        set_gen(2, 0, 0, 0);
        repeat (8) begin
            repeat ($urandom_range(200, 600)) @(posedge clk);
            #1 ena = 1'b0;
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 ena = 1'b1;
        end
        repeat (200) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
